voice_alloc: RTL and testbench
==============================

# voice_alloc

Note-event front end of the polyphonic envelope loop. It accepts MIDI note-on/note-off events through a valid/ready handshake and scans the per-voice envelope states to pick a target voice. It then issues one flag write per event, setting the `note_pressed` or `note_released` request bit of that voice. The time-multiplexed ADSR update consumes and clears these bits. The block also owns the voice-to-note table used by the oscillators.

## Interface

Parameters:
- NB_VOICE, 16, number of voices; power of two, ≥ 2.
- VOICE_W, 4, log2(NB_VOICE).

Ports:
- clk, input, 1, single system clock; everything is on the rising edge.
- rst_n, input, 1, reset; synchronous, active-low.
- ev_valid, input, 1, event present.
- ev_ready, output, 1, block can accept an event.
- ev_note_on, input, 1, 1 = note-on, 0 = note-off.
- ev_note, input, 7, MIDI note number.
- vs_addr, output, VOICE_W, voice-state RAM read address.
- vs_state, input, 3, envelope state of the voice at `vs_addr`, valid one cycle after the address (0 BLANK, 1 ATTACK, 2 DECAY, 3 SUSTAIN, 4 RELEASE).
- fl_we, output, 1, one-cycle flag-write strobe.
- fl_addr, output, VOICE_W, voice written.
- fl_pressed, output, 1, set the `note_pressed` request.
- fl_released, output, 1, set the `note_released` request.
- fl_note, output, 7, note number for the voice; oscillators latch it on `fl_we & fl_pressed`.

## Operation

**Internal state**
- `own[v]` (1 bit) and `note_tab[v]` (7 bits) for each voice.
- `steal_ptr` (VOICE_W bits).
- Latched event: `on`, `note`.
- Scan result:
  - `hit_v`/`hit`: first owned voice with `note_tab == note`.
  - `free_v`/`free`: first voice with `vs_state == 0`.
- FSM: IDLE, SCAN, WRITE.

**IDLE**
- `ev_ready = 1`.
- On `ev_valid & ev_ready`: latch `ev_note_on` and `ev_note`, clear `hit`/`free`, set scan counter to 0, go to SCAN.

**SCAN**
- `vs_addr` = counter; the counter advances 0..NB_VOICE−1.
- The `vs_state` sample for voice i is evaluated in the cycle after `vs_addr = i`.
- The match on `own`/`note_tab` for voice i is evaluated in that same cycle.
- Only the lowest-index hit and the lowest-index free voice are recorded.
- After the last voice is evaluated, go to WRITE.

**WRITE** (`fl_we = 1` for exactly one cycle, unless the event is dropped)
- Note-on:
  - Target priority is `hit_v`, then `free_v`, then `steal_ptr`.
  - Outputs: `fl_pressed = 1`, `fl_released = 0`, `fl_note = note`.
  - Table update: `own[target] = 1`, `note_tab[target] = note`.
  - `steal_ptr` increments (wrapping NB_VOICE−1 → 0) only when the voice was stolen.
- Note-off with `hit`:
  - `fl_addr = hit_v`, `fl_released = 1`, `fl_pressed = 0`, `fl_note = note`.
  - Table update: `own[hit_v] = 0`.
- Note-off without `hit`: `fl_we` stays 0; the event is dropped.
- Next state is IDLE.

**Rules**
- `fl_pressed` and `fl_released` are never both 1.
- Both are 0 whenever `fl_we = 0`.
- A retriggered voice (hit on note-on) keeps its ownership.
- A voice in RELEASE that was owned by an earlier note is not free. It becomes free only once its envelope reaches BLANK.

## Timing

**Reset** (`rst_n = 0` on a clock edge):
- Outputs: `ev_ready = 0`, `fl_we = 0`, `fl_addr = 0`, `fl_pressed = 0`, `fl_released = 0`, `fl_note = 0`, `vs_addr = 0`.
- Internal: all `own = 0`, `note_tab = 0`, `steal_ptr = 0`, FSM = IDLE.
- Reset in SCAN or WRITE aborts the event with no flag write.
- `ev_ready = 1` from the first cycle after `rst_n` returns high.

**Event timeline** (handshake at cycle T):
- `ev_ready = 0` from T+1.
- `vs_addr = i` at T+1+i.
- The last `vs_state` sample is taken at T+1+NB_VOICE.
- `fl_we` is asserted at T+2+NB_VOICE.
- `ev_ready = 1` again at T+3+NB_VOICE.
- Maximum throughput is one event per NB_VOICE+3 cycles.

**Handshake and flags**
- `ev_valid` may stay high. Holding the event stable while `ev_ready = 0` is the producer's job.
- Event inputs are ignored outside the handshake cycle.
- `fl_addr`, `fl_pressed`, `fl_released` and `fl_note` are registered and valid only while `fl_we = 1`.
- `vs_addr` holds NB_VOICE−1 after the scan, until the next scan.

## Test plan

- **Basic note-on**: reset, all `vs_state = 0`, note-on 60 → `fl_we` at T+18 (NB_VOICE=16), `fl_addr = 0`, `fl_pressed = 1`, `fl_note = 60`; `ev_ready` high at T+19.
- **Free-voice skip**: voices 0–2 in states 1/3/4, voice 3 BLANK, note-on 64 → `fl_addr = 3`.
- **Retrigger and release**:
  - After note-on 60 lands on voice 0, set voice 0 to SUSTAIN.
  - A second note-on 60 → `fl_addr = 0`, `fl_pressed = 1`.
  - Note-off 60 → `fl_addr = 0`, `fl_released = 1`.
  - A second note-off 60 → no `fl_we`.
- **Stealing**: all 16 voices non-BLANK and owned by notes 0–15.
  - Note-on 100 → `fl_addr = 0`; note-on 101 → `fl_addr = 1`.
  - After 16 steals, `steal_ptr` wraps and `fl_addr = 0`.
- **Reset mid-scan**: assert `rst_n = 0` at T+5 of a note-on → no `fl_we`, all `own` cleared; the next note-off for that note is dropped.
- **Back-to-back events**: `ev_valid` held high with two events → second handshake exactly at T+3+NB_VOICE, no flag write overlap.

Source files
------------

// File: rtl/voice_alloc_if.sv
// Purpose : note-event handshake, voice-state read port and flag-write port of voice_alloc.
// Latency : n/a (signal bundle only).
// Backpressure: ev_valid/ev_ready handshake; the flag-write port has no backpressure.
//
// Ports (slave = allocator side):
//   ev_valid/ev_ready/ev_note_on/ev_note : note event handshake
//   vs_addr -> / <- vs_state             : voice-state RAM read, data one cycle after address
//   fl_we/fl_addr/fl_pressed/fl_released/fl_note : one-cycle flag write to the ADSR loop
interface voice_alloc_if #(
  parameter int VOICE_W = 4
);
  logic               ev_valid;
  logic               ev_ready;
  logic               ev_note_on;
  logic [6:0]         ev_note;
  logic [VOICE_W-1:0] vs_addr;
  logic [2:0]         vs_state;
  logic               fl_we;
  logic [VOICE_W-1:0] fl_addr;
  logic               fl_pressed;
  logic               fl_released;
  logic [6:0]         fl_note;

  modport slave (
    input  ev_valid, ev_note_on, ev_note, vs_state,
    output ev_ready, vs_addr, fl_we, fl_addr, fl_pressed, fl_released, fl_note
  );

  modport master (
    output ev_valid, ev_note_on, ev_note, vs_state,
    input  ev_ready, vs_addr, fl_we, fl_addr, fl_pressed, fl_released, fl_note
  );
endinterface

// File: rtl/voice_alloc.sv
// Purpose : picks a voice for each MIDI note event and issues one pressed/released flag write.
// Latency : flag write NB_VOICE+2 cycles after the handshake; ready again one cycle later.
// Backpressure: ev_ready is low from the cycle after a handshake until the flag write has retired.
//
// Ports:
//   clk, rst_n : system clock, synchronous active-low reset
//   bus        : voice_alloc_if.slave (event handshake, voice-state read, flag write)
module voice_alloc #(
  parameter int NB_VOICE = 16,
  parameter int VOICE_W  = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  voice_alloc_if.slave  bus
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SCAN  = 2'd1;
  localparam logic [1:0] ST_WRITE = 2'd2;

  // Scan step NB_VOICE is the one where the last voice's state sample is evaluated.
  localparam logic [VOICE_W:0]   LP_LAST = (VOICE_W+1)'(NB_VOICE);
  localparam logic [VOICE_W-1:0] LP_VMAX = VOICE_W'(NB_VOICE - 1);

  logic [1:0]          r_state;
  logic [NB_VOICE-1:0] r_own;
  logic [6:0]          r_note_tab [NB_VOICE];
  logic [VOICE_W-1:0]  r_steal_ptr;
  logic                r_on;
  logic [6:0]          r_note;
  logic                r_hit;
  logic [VOICE_W-1:0]  r_hit_v;
  logic                r_free;
  logic [VOICE_W-1:0]  r_free_v;
  logic [VOICE_W:0]    r_step;
  logic [VOICE_W-1:0]  r_vs_addr;
  logic                r_ev_ready;
  logic                r_fl_we;
  logic [VOICE_W-1:0]  r_fl_addr;
  logic                r_fl_pressed;
  logic                r_fl_released;
  logic [6:0]          r_fl_note;

  logic                w_eval;
  logic [VOICE_W-1:0]  w_eval_v;
  logic                w_is_hit;
  logic                w_is_free;
  logic                w_hit;
  logic [VOICE_W-1:0]  w_hit_v;
  logic                w_free;
  logic [VOICE_W-1:0]  w_free_v;
  logic                w_last;
  logic [VOICE_W-1:0]  w_tgt;
  logic                w_steal;

  // vs_state lags vs_addr by one cycle, so step k evaluates voice k-1.
  assign w_eval    = (r_state == ST_SCAN) && (r_step != '0);
  assign w_eval_v  = r_step[VOICE_W-1:0] - VOICE_W'(1);
  assign w_is_hit  = w_eval && r_own[w_eval_v] && (r_note_tab[w_eval_v] == r_note);
  assign w_is_free = w_eval && (bus.vs_state == 3'd0);

  // Keep only the lowest-index match: once recorded, later matches are ignored.
  assign w_hit    = r_hit  | w_is_hit;
  assign w_hit_v  = r_hit  ? r_hit_v  : w_eval_v;
  assign w_free   = r_free | w_is_free;
  assign w_free_v = r_free ? r_free_v : w_eval_v;
  assign w_last   = (r_state == ST_SCAN) && (r_step == LP_LAST);

  // Note-on target: retrigger an owned voice, else a blank one, else steal round-robin.
  always_comb begin
    w_tgt   = r_steal_ptr;
    w_steal = 1'b0;
    if (w_hit) begin
      w_tgt = w_hit_v;
    end else if (w_free) begin
      w_tgt = w_free_v;
    end else begin
      w_steal = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_own         <= '0;
      for (int i = 0; i < NB_VOICE; i++) begin
        r_note_tab[i] <= '0;
      end
      r_steal_ptr   <= '0;
      r_on          <= 1'b0;
      r_note        <= '0;
      r_hit         <= 1'b0;
      r_hit_v       <= '0;
      r_free        <= 1'b0;
      r_free_v      <= '0;
      r_step        <= '0;
      r_vs_addr     <= '0;
      r_ev_ready    <= 1'b0;
      r_fl_we       <= 1'b0;
      r_fl_addr     <= '0;
      r_fl_pressed  <= 1'b0;
      r_fl_released <= 1'b0;
      r_fl_note     <= '0;
    end else begin
      // Flag strobes are single-cycle; address/note simply hold.
      r_fl_we       <= 1'b0;
      r_fl_pressed  <= 1'b0;
      r_fl_released <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          if (r_ev_ready && bus.ev_valid) begin
            r_on       <= bus.ev_note_on;
            r_note     <= bus.ev_note;
            r_hit      <= 1'b0;
            r_free     <= 1'b0;
            r_step     <= '0;
            r_vs_addr  <= '0;
            r_ev_ready <= 1'b0;
            r_state    <= ST_SCAN;
          end else begin
            // Also covers the first cycle out of reset, where ready is still low.
            r_ev_ready <= 1'b1;
          end
        end

        ST_SCAN: begin
          r_hit    <= w_hit;
          r_hit_v  <= w_hit_v;
          r_free   <= w_free;
          r_free_v <= w_free_v;
          r_step   <= r_step + (VOICE_W+1)'(1);
          if (r_vs_addr != LP_VMAX) begin
            r_vs_addr <= r_vs_addr + VOICE_W'(1);
          end
          if (w_last) begin
            r_state   <= ST_WRITE;
            r_fl_note <= r_note;
            if (r_on) begin
              r_fl_we             <= 1'b1;
              r_fl_pressed        <= 1'b1;
              r_fl_addr           <= w_tgt;
              r_own[w_tgt]        <= 1'b1;
              r_note_tab[w_tgt]   <= r_note;
              if (w_steal) begin
                r_steal_ptr <= r_steal_ptr + VOICE_W'(1);
              end
            end else if (w_hit) begin
              r_fl_we         <= 1'b1;
              r_fl_released   <= 1'b1;
              r_fl_addr       <= w_hit_v;
              r_own[w_hit_v]  <= 1'b0;
            end
            // Note-off for a note nobody holds: nothing to write.
          end
        end

        ST_WRITE: begin
          r_state    <= ST_IDLE;
          r_ev_ready <= 1'b1;
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.ev_ready    = r_ev_ready;
  assign bus.vs_addr     = r_vs_addr;
  assign bus.fl_we       = r_fl_we;
  assign bus.fl_addr     = r_fl_addr;
  assign bus.fl_pressed  = r_fl_pressed;
  assign bus.fl_released = r_fl_released;
  assign bus.fl_note     = r_fl_note;

endmodule

// File: tb/tb_voice_alloc.sv
// Purpose : self-checking bench for voice_alloc with a table-level allocation model.
// Latency : model expects the flag write at T+18 and ready again at T+19 (16 voices).
// Backpressure: producer holds or drops ev_valid; ready is predicted by the model.
module tb_voice_alloc;
  localparam int NBV = 16;

  logic clk;
  logic rst_n;

  voice_alloc_if #(.VOICE_W(4)) bus ();

  voice_alloc #(.NB_VOICE(NBV), .VOICE_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Voice-state RAM: one-cycle read latency.
  logic [2:0] vs_mem [NBV];
  always @(posedge clk) bus.vs_state <= vs_mem[bus.vs_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Allocation model: ownership/note table and steal pointer as plain arrays.
  bit  m_own [NBV];
  int  m_tab [NBV];
  int  m_steal;
  bit  chk_en = 0;
  bit  pend = 0;
  bit  scan_on = 0;
  int  we_cyc, rdy_cyc, hs_cyc, hs_count = 0;
  int  e_addr, e_note;
  bit  e_pr, e_rel;
  int  mh, mf, mt;

  // Observed writes (for the per-event literal checks).
  int  wr_count = 0;
  int  last_addr, last_note, last_we_cyc;
  bit  last_pr, last_rel;

  always @(negedge clk) begin
    bit exp_we;
    int ea;
    if (chk_en) begin
      exp_we = pend && (cyc == we_cyc);
      chk("fl_we", bus.fl_we, exp_we);
      if (exp_we && bus.fl_we) begin
        chk("fl_addr", bus.fl_addr, e_addr);
        chk("fl_pressed", bus.fl_pressed, e_pr);
        chk("fl_released", bus.fl_released, e_rel);
        chk("fl_note", bus.fl_note, e_note);
      end else begin
        chk("fl_pressed_idle", bus.fl_pressed, 0);
        chk("fl_released_idle", bus.fl_released, 0);
      end
      chk("ev_ready", bus.ev_ready, (cyc >= rdy_cyc));
      if (scan_on && cyc >= hs_cyc + 1 && cyc <= hs_cyc + 17) begin
        ea = cyc - hs_cyc - 1;
        if (ea > NBV - 1) ea = NBV - 1;
        chk("vs_addr", bus.vs_addr, ea);
      end
      if (bus.fl_we === 1'b1) begin
        wr_count++;
        last_addr   = bus.fl_addr;
        last_note   = bus.fl_note;
        last_pr     = bus.fl_pressed;
        last_rel    = bus.fl_released;
        last_we_cyc = cyc;
      end
    end

    if (rst_n !== 1'b1) begin
      for (int v = 0; v < NBV; v++) begin
        m_own[v] = 0;
        m_tab[v] = 0;
      end
      m_steal = 0;
      chk_en  = 1;
      pend    = 0;
      scan_on = 0;
      rdy_cyc = cyc + 2;
    end else if (chk_en && bus.ev_valid && cyc >= rdy_cyc) begin
      hs_cyc  = cyc;
      hs_count++;
      rdy_cyc = cyc + 19;
      we_cyc  = cyc + 18;
      scan_on = 1;
      e_note  = bus.ev_note;
      mh = -1;
      mf = -1;
      for (int v = 0; v < NBV; v++) begin
        if (mh < 0 && m_own[v] && m_tab[v] == e_note) mh = v;
        if (mf < 0 && vs_mem[v] == 3'd0) mf = v;
      end
      if (bus.ev_note_on) begin
        if (mh >= 0) mt = mh;
        else if (mf >= 0) mt = mf;
        else begin
          mt = m_steal;
          m_steal = (m_steal + 1) % NBV;
        end
        m_own[mt] = 1;
        m_tab[mt] = e_note;
        pend = 1; e_addr = mt; e_pr = 1; e_rel = 0;
      end else if (mh >= 0) begin
        m_own[mh] = 0;
        pend = 1; e_addr = mh; e_pr = 0; e_rel = 1;
      end else begin
        pend = 0;
      end
    end
  end

  bit got_we;

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("rst_ev_ready", bus.ev_ready, 0);
    chk("rst_fl_we", bus.fl_we, 0);
    chk("rst_fl_addr", bus.fl_addr, 0);
    chk("rst_fl_pressed", bus.fl_pressed, 0);
    chk("rst_fl_released", bus.fl_released, 0);
    chk("rst_fl_note", bus.fl_note, 0);
    chk("rst_vs_addr", bus.vs_addr, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_ready_after", bus.ev_ready, 1);
  endtask

  // Present an event and wait for its handshake; returns at T+1 with ev_valid still high.
  task automatic start_ev(input bit on, input int note);
    int hc0;
    bit seen;
    hc0 = hs_count;
    seen = 0;
    bus.ev_note_on = on;
    bus.ev_note    = 7'(note);
    bus.ev_valid   = 1'b1;
    for (int k = 0; k < 200 && !seen; k++) begin
      @(posedge clk); #1;
      if (hs_count != hc0) seen = 1;
    end
    if (!seen) chk("handshake_timeout", 0, 1);
  endtask

  task automatic wait_done();
    for (int k = 0; k < 60 && cyc < hs_cyc + 19; k++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic send(input bit on, input int note);
    int wb;
    wb = wr_count;
    start_ev(on, note);
    bus.ev_valid = 1'b0;
    wait_done();
    got_we = (wr_count != wb);
    // Envelope stand-in: pressed starts ATTACK, released enters RELEASE.
    if (got_we) vs_mem[last_addr] = last_pr ? 3'd1 : 3'd4;
  endtask

  task automatic expect_we(input string name, input int addr, input bit pr, input int note);
    chk({name, "_we"}, got_we, 1);
    chk({name, "_addr"}, last_addr, addr);
    chk({name, "_pressed"}, last_pr, pr);
    chk({name, "_released"}, last_rel, !pr);
    chk({name, "_note"}, last_note, note);
  endtask

  task automatic clear_vs();
    for (int v = 0; v < NBV; v++) vs_mem[v] = 3'd0;
  endtask

  initial begin
    int wb, h1, h2;
    rst_n = 1'b0;
    bus.ev_valid = 1'b0;
    bus.ev_note_on = 1'b0;
    bus.ev_note = 7'd0;
    clear_vs();
    @(posedge clk); #1;
    do_reset();

    // Basic note-on into an all-blank pool.
    send(1, 60);
    expect_we("basic", 0, 1, 60);
    chk("basic_latency", last_we_cyc - hs_cyc, 18);
    chk("basic_ready_back", bus.ev_ready, 1);

    // Retrigger keeps the voice; release frees ownership; repeated note-off is dropped.
    vs_mem[0] = 3'd3;
    send(1, 60);
    expect_we("retrig", 0, 1, 60);
    send(0, 60);
    expect_we("release", 0, 0, 60);
    send(0, 60);
    chk("noteoff_drop", got_we, 0);

    // Free-voice skip over ATTACK/SUSTAIN/RELEASE.
    do_reset();
    clear_vs();
    vs_mem[0] = 3'd1;
    vs_mem[1] = 3'd3;
    vs_mem[2] = 3'd4;
    send(1, 64);
    expect_we("free_skip", 3, 1, 64);

    // Stealing: fill every voice, then steal round-robin and wrap.
    do_reset();
    clear_vs();
    for (int n = 0; n < NBV; n++) begin
      send(1, n);
      chk("fill_addr", last_addr, n);
    end
    send(1, 100);
    expect_we("steal0", 0, 1, 100);
    send(1, 101);
    expect_we("steal1", 1, 1, 101);
    for (int n = 102; n < 116; n++) send(1, n);
    chk("steal15_addr", last_addr, 15);
    send(1, 116);
    expect_we("steal_wrap", 0, 1, 116);

    // Reset mid-scan aborts the event and clears ownership.
    do_reset();
    clear_vs();
    send(1, 70);
    expect_we("pre_abort", 0, 1, 70);
    wb = wr_count;
    start_ev(1, 70);
    bus.ev_valid = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    do_reset();
    repeat (20) begin @(posedge clk); #1; end
    chk("abort_no_we", wr_count - wb, 0);
    send(0, 70);
    chk("abort_noteoff_drop", got_we, 0);

    // Back-to-back with ev_valid held high.
    wb = wr_count;
    start_ev(1, 50);
    h1 = hs_cyc;
    start_ev(1, 52);
    h2 = hs_cyc;
    bus.ev_valid = 1'b0;
    wait_done();
    chk("b2b_gap", h2 - h1, 19);
    chk("b2b_writes", wr_count - wb, 2);
    chk("b2b_last_note", last_note, 52);

    repeat (3) begin @(posedge clk); #1; end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end
endmodule
